// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-word-memory bridge.
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        DONE
    } state_t;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;

    // Mode 2'b11 falls into the default branch and behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] addr_lo);
        case (mode)
            MODE_HALF: return addr_lo[0];
            MODE_BYTE: return 1'b0;
            default:   return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_bridge_lane.sv
// byte_lane: little-endian lane extraction with sign/zero extension, and
// lane merge of store data into a read word for read-modify-write.
module byte_lane
    import mem_bridge_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_mode,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every output of a combinational block gets a value before any
    // branch, otherwise the missing paths infer latches.
    always_comb begin
        w_byte   = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half   = i_word[{i_addr_lo[1], 4'b0000} +: 16];
        o_load   = i_word;
        o_merged = i_wdata;
        case (i_mode)
            MODE_HALF: begin
                o_load   = {{16{i_signed & w_half[15]}}, w_half};
                o_merged = i_word;
                o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            MODE_BYTE: begin
                o_load   = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merged = i_word;
                o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// CPU load/store port to a word-wide memory with handshake, sub-word
// read-modify-write, misalignment detection and acknowledge timeout.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpuRead,
    input  logic        cpuWrite,
    input  logic [1:0]  cpuMode,
    input  logic        cpuSigned,
    input  logic [31:0] cpuAddr,
    input  logic [31:0] cpuWData,
    output logic [31:0] cpuRData,
    output logic        cpuStall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic        errMisalign,
    output logic        errTimeout
);

    localparam int                WAIT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(TIMEOUT_CYCLES);

    state_t            r_state, w_next;
    logic [WAIT_W-1:0] r_wait, w_wait_inc;
    logic              r_mem_req, r_mem_we;
    logic [31:0]       r_mem_addr, r_mem_wdata, r_cpu_rdata;
    logic [1:0]        r_addr_lo, r_mode;
    logic              r_signed, r_err_mis, r_err_to;
    logic              w_req_present, w_misaligned, w_sub_word, w_timeout;
    logic [31:0]       w_load, w_merged;

    assign w_req_present = cpuRead | cpuWrite;
    assign w_misaligned  = is_misaligned(cpuMode, cpuAddr[1:0]);
    assign w_sub_word    = (cpuMode == MODE_HALF) || (cpuMode == MODE_BYTE);

    // During RMW_RD the held memWData register still carries the store data.
    byte_lane u_lane (
        .i_word   (memRData),
        .i_addr_lo(r_addr_lo),
        .i_mode   (r_mode),
        .i_signed (r_signed),
        .i_wdata  (r_mem_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_comb begin
        w_next     = r_state;
        w_wait_inc = r_wait + WAIT_W'(1);
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_present) begin
                    if (w_misaligned)  w_next = DONE;
                    else if (cpuWrite) w_next = w_sub_word ? RMW_RD : WR;
                    else               w_next = RD;
                end
            end
            RD, RMW_RD, WR: begin
                if (memAck) begin
                    w_next = (r_state == RMW_RD) ? WR : DONE;
                end else if (w_wait_inc == WAIT_LIMIT) begin
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cpuStall = 1'b0;
        if (rst) begin
            cpuStall = w_req_present;
        end else begin
            case (r_state)
                IDLE:           cpuStall = w_req_present;
                RD, RMW_RD, WR: cpuStall = 1'b1;
                default:        cpuStall = 1'b0;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_addr_lo   <= '0;
            r_mode      <= MODE_WORD;
            r_signed    <= 1'b0;
            r_err_mis   <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_present) begin
                        r_addr_lo <= cpuAddr[1:0];
                        r_mode    <= cpuMode;
                        r_signed  <= cpuSigned;
                        if (w_misaligned) begin
                            r_err_mis <= 1'b1;
                            if (!cpuWrite) r_cpu_rdata <= '0;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= cpuWrite & ~w_sub_word;
                            r_mem_addr  <= {cpuAddr[31:2], 2'b00};
                            r_mem_wdata <= cpuWData;
                            r_wait      <= '0;
                        end
                    end
                end
                RD, RMW_RD, WR: begin
                    if (memAck) begin
                        r_wait <= '0;
                        if (r_state == RMW_RD) begin
                            r_mem_wdata <= w_merged;
                            r_mem_we    <= 1'b1;
                        end else begin
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                            if (r_state == RD) r_cpu_rdata <= w_load;
                        end
                    end else if (w_timeout) begin
                        r_wait    <= '0;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_err_to  <= 1'b1;
                        if (r_state == RD) r_cpu_rdata <= '0;
                    end else begin
                        r_wait <= w_wait_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign memReq      = r_mem_req;
    assign memWe       = r_mem_we;
    assign memAddr     = r_mem_addr;
    assign memWData    = r_mem_wdata;
    assign cpuRData    = r_cpu_rdata;
    assign errMisalign = r_err_mis;
    assign errTimeout  = r_err_to;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed vector table, reset/ack corner
// sequences, and randomized transactions against a behavioural model.
module tb_mem_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpuRead = 1'b0, cpuWrite = 1'b0, cpuSigned = 1'b0;
    logic [1:0]  cpuMode = 2'b00;
    logic [31:0] cpuAddr = '0, cpuWData = '0;
    logic [31:0] cpuRData;
    logic        cpuStall, memReq, memWe;
    logic [31:0] memAddr, memWData;
    logic        memAck = 1'b0;
    logic [31:0] memRData = '0;
    logic        errMisalign, errTimeout;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuMode(cpuMode), .cpuSigned(cpuSigned),
        .cpuAddr(cpuAddr), .cpuWData(cpuWData), .cpuRData(cpuRData), .cpuStall(cpuStall),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memAck(memAck), .memRData(memRData),
        .errMisalign(errMisalign), .errTimeout(errTimeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic bit ref_misaligned(input logic [1:0] mode, input logic [31:0] a);
        if (mode == 2'b10) return 1'b0;
        if (mode == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] mode, input logic sgn);
        logic [31:0] v;
        if (mode == 2'b10) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (mode == 2'b01) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [31:0] a, input logic [1:0] mode);
        logic [31:0] m;
        int          sh;
        if (mode == 2'b10) begin
            sh = 8 * (a % 4);
            m  = 32'hFF << sh;
        end else if (mode == 2'b01) begin
            sh = 16 * ((a / 2) % 2);
            m  = 32'hFFFF << sh;
        end else begin
            return d;
        end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    // Request cycles spent in one memory phase given the responder's ack delay.
    function automatic int phase_cycles(input int d);
        return (d < TMO) ? d + 1 : TMO;
    endfunction

    // ---------------- transaction driver / memory responder ----------------
    task automatic run_txn(input logic wr, input logic rd, input logic [1:0] mode, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int d1, input int d2,
                           output int stalls, output bit saw_req, output bit addr_ok,
                           output bit req_low_done, output bit finished);
        int delays [2];
        int phase;
        int waitc;
        delays[0] = d1;
        delays[1] = d2;
        phase = 0;
        waitc = 0;
        stalls = 0;
        saw_req = 1'b0;
        addr_ok = 1'b1;
        req_low_done = 1'b0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            @(negedge clk);
            memAck   = 1'b0;
            memRData = $urandom;
            if (cyc == 0) begin
                cpuRead = rd; cpuWrite = wr; cpuMode = mode; cpuSigned = sgn;
                cpuAddr = addr; cpuWData = wdata;
            end else begin
                cpuRead = 1'b0; cpuWrite = 1'b0;
            end
            #1;
            if (cyc > 0 && !cpuStall) begin
                finished     = 1'b1;
                req_low_done = !memReq;
                // A stray ack during DONE must be ignored.
                memAck = 1'b1;
            end else begin
                if (cpuStall) stalls++;
                if (memReq) begin
                    saw_req = 1'b1;
                    if (memAddr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
                    if (phase < 2 && waitc == delays[phase]) begin
                        memAck   = 1'b1;
                        memRData = mem[memAddr[7:2]];
                        if (memWe) mem[memAddr[7:2]] = memWData;
                        phase++;
                        waitc = 0;
                    end else begin
                        waitc++;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cpuRead = 1'b0; cpuWrite = 1'b0; memAck = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  mode;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init_word;
        int          d1;
        int          d2;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        int          exp_stall;
        logic        exp_mis;
        logic        exp_to;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int          stalls;
        bit          saw_req, addr_ok, req_low, fin, bad;
        logic [31:0] snap;

        vecs[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h104, 32'h0,        32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'b10, 1'b1, 32'h103, 32'h0,        32'h80112233, 0, 0, 32'hFFFFFF80, 32'h80112233, 2, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h103, 32'h0,        32'h80112233, 0, 0, 32'h00000080, 32'h80112233, 2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h11223344, 0, 0, 32'h0,        32'hABCD3344, 3, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h105, 32'h12345678, 32'h55AA55AA, 0, 0, 32'h0,        32'h55AA55AA, 1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h108, 32'h0,        32'h01020304, 9, 0, 32'h0,        32'h01020304, 5, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 2'b01, 1'b1, 32'h106, 32'h0,        32'h80017FFF, 0, 0, 32'hFFFF8001, 32'h80017FFF, 2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h104, 32'h0,        32'h8001F00F, 0, 0, 32'h0000F00F, 32'h8001F00F, 2, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h123456EE, 32'h11223344, 0, 0, 32'h0,        32'h1122EE44, 3, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h10C, 32'hCAFEF00D, 32'h00000000, 1, 0, 32'h0,        32'hCAFEF00D, 3, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b11, 1'b1, 32'h110, 32'h0,        32'h01234567, 0, 0, 32'h01234567, 32'h01234567, 2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h111, 32'h0,        32'h89ABCDEF, 0, 0, 32'h0,        32'h89ABCDEF, 1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h000000FF, 32'hA5A5A5A5, 9, 0, 32'h0,        32'hA5A5A5A5, 5, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h103, 32'h00000077, 32'h00000000, 0, 1, 32'h0,        32'h77000000, 4, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'b10, 1'b1, 32'h100, 32'h0,        32'h0000007F, 3, 0, 32'h0000007F, 32'h0000007F, 5, 1'b0, 1'b0};

        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Reset state, and stall while reset is held.
        repeat (2) @(negedge clk);
        #1;
        check("rst_memReq", memReq, 1'b0);
        check("rst_memWe", memWe, 1'b0);
        check("rst_memAddr", memAddr, 32'h0);
        check("rst_memWData", memWData, 32'h0);
        check("rst_cpuRData", cpuRData, 32'h0);
        check("rst_errs", {errMisalign, errTimeout}, 2'b00);
        check("rst_stall_idle", cpuStall, 1'b0);
        cpuRead = 1'b1;
        #1;
        check("rst_stall_req", cpuStall, 1'b1);
        @(negedge clk);
        #1;
        check("rst_holds_idle", memReq, 1'b0);
        cpuRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int v = 0; v < 15; v++) begin
            do_reset();
            mem[vecs[v].addr[7:2]] = vecs[v].init_word;
            run_txn(vecs[v].wr, vecs[v].rd, vecs[v].mode, vecs[v].sgn, vecs[v].addr, vecs[v].wdata,
                    vecs[v].d1, vecs[v].d2, stalls, saw_req, addr_ok, req_low, fin);
            check($sformatf("v%0d_finished", v), fin, 1'b1);
            check($sformatf("v%0d_stall", v), 32'(stalls), 32'(vecs[v].exp_stall));
            check($sformatf("v%0d_rdata", v), cpuRData, vecs[v].exp_rdata);
            check($sformatf("v%0d_word", v), mem[vecs[v].addr[7:2]], vecs[v].exp_word);
            check($sformatf("v%0d_errMis", v), errMisalign, vecs[v].exp_mis);
            check($sformatf("v%0d_errTo", v), errTimeout, vecs[v].exp_to);
            check($sformatf("v%0d_memReq_seen", v), saw_req, !vecs[v].exp_mis);
            check($sformatf("v%0d_memAddr", v), addr_ok, 1'b1);
            check($sformatf("v%0d_req_low_done", v), req_low, 1'b1);
        end

        // Reset in RMW_RD abandons the store; later acks do nothing.
        do_reset();
        mem[6'h30] = 32'h11223344;
        @(negedge clk);
        cpuWrite = 1'b1; cpuRead = 1'b0; cpuMode = 2'b10; cpuAddr = 32'h0C1; cpuWData = 32'h99;
        @(negedge clk);
        cpuWrite = 1'b0;
        #1;
        check("rmw_req_up", {memReq, memWe}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_memReq", memReq, 1'b0);
        check("rst_mid_stall", cpuStall, 1'b0);
        check("rst_mid_memAddr", memAddr, 32'h0);
        snap = cpuRData;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            memAck = 1'b1;
            memRData = $urandom;
            #1;
            if (memReq || memWe || cpuStall) bad = 1'b1;
        end
        @(negedge clk);
        memAck = 1'b0;
        #1;
        check("late_ack_ignored", bad, 1'b0);
        check("late_ack_rdata", cpuRData, snap);
        check("late_ack_word", mem[6'h30], 32'h11223344);

        // Randomized transactions, no reset between them: sticky flags and held data.
        do_reset();
        begin
            logic        ref_mis, ref_to;
            logic [31:0] ref_rdata;
            for (int i = 0; i < 64; i++) begin
                mem[i]     = $urandom;
                ref_mem[i] = mem[i];
            end
            ref_mis = 1'b0;
            ref_to = 1'b0;
            ref_rdata = 32'h0;
            for (int t = 0; t < 200; t++) begin
                int          op, d1, d2, exp_stall;
                logic        wr, rd, sgn, mis;
                logic [1:0]  mode;
                logic [31:0] addr, wdata;
                op    = $urandom_range(0, 2);
                wr    = (op != 0);
                rd    = (op != 1);
                mode  = 2'($urandom_range(0, 3));
                sgn   = 1'($urandom_range(0, 1));
                addr  = 32'($urandom_range(0, 255));
                wdata = $urandom;
                d1    = $urandom_range(0, 5);
                d2    = $urandom_range(0, 5);
                mis   = ref_misaligned(mode, addr);

                if (mis) begin
                    exp_stall = 1;
                    ref_mis = 1'b1;
                    if (!wr) ref_rdata = 32'h0;
                end else if (!wr) begin
                    exp_stall = 1 + phase_cycles(d1);
                    if (d1 < TMO) ref_rdata = ref_load(ref_mem[addr[7:2]], addr, mode, sgn);
                    else begin ref_rdata = 32'h0; ref_to = 1'b1; end
                end else if (mode == 2'b01 || mode == 2'b10) begin
                    exp_stall = 1 + phase_cycles(d1);
                    if (d1 >= TMO) ref_to = 1'b1;
                    else begin
                        exp_stall += phase_cycles(d2);
                        if (d2 >= TMO) ref_to = 1'b1;
                        else ref_mem[addr[7:2]] = ref_store(ref_mem[addr[7:2]], wdata, addr, mode);
                    end
                end else begin
                    exp_stall = 1 + phase_cycles(d1);
                    if (d1 >= TMO) ref_to = 1'b1;
                    else ref_mem[addr[7:2]] = wdata;
                end

                run_txn(wr, rd, mode, sgn, addr, wdata, d1, d2, stalls, saw_req, addr_ok, req_low, fin);
                check($sformatf("r%0d_finished", t), fin, 1'b1);
                check($sformatf("r%0d_stall", t), 32'(stalls), 32'(exp_stall));
                check($sformatf("r%0d_rdata", t), cpuRData, ref_rdata);
                check($sformatf("r%0d_word", t), mem[addr[7:2]], ref_mem[addr[7:2]]);
                check($sformatf("r%0d_errs", t), {errMisalign, errTimeout}, {ref_mis, ref_to});
                check($sformatf("r%0d_memReq_seen", t), saw_req, !mis);
                check($sformatf("r%0d_memAddr", t), addr_ok, 1'b1);
                check($sformatf("r%0d_req_low_done", t), req_low, 1'b1);
            end
            bad = 1'b0;
            for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad = 1'b1;
            check("final_memory_image", bad, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of cycles to wait for memAck per memory transaction.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 cpuRead  input  1  SHALL request a load.
REQ-005 cpuWrite  input  1  SHALL request a store.
REQ-006 cpuMode  input  2  SHALL give access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-007 cpuSigned  input  1  SHALL select sign extension of sub-word load data; 0 gives zero extension.
REQ-008 cpuAddr  input  32  SHALL be the byte address.
REQ-009 cpuWData  input  32  SHALL be store data, right-aligned.
REQ-010 cpuRData  output  32  SHALL be the registered, extended load result.
REQ-011 cpuStall  output  1  SHALL freeze the CPU PC and register writes while high.
REQ-012 memReq  output  1  SHALL be the registered request to the word memory.
REQ-013 memWe  output  1  SHALL mark the request as a write.
REQ-014 memAddr  output  32  SHALL be the word address, {cpuAddr[31:2],2'b00}.
REQ-015 memWData  output  32  SHALL be the full word to write.
REQ-016 memAck  input  1  SHALL complete the outstanding request in the cycle it is sampled high.
REQ-017 memRData  input  32  SHALL be the read word, valid when memAck is high.
REQ-018 errMisalign  output  1  SHALL be a sticky flag for a misaligned access.
REQ-019 errTimeout  output  1  SHALL be a sticky flag for an acknowledge timeout.

Function
REQ-020 The FSM SHALL have these states: IDLE, RD, RMW_RD, WR and DONE.
REQ-021 In IDLE with cpuWrite=1 the FSM SHALL go to WR for a word store or to RMW_RD for a byte or halfword store; write wins if cpuRead=1 as well.
REQ-022 In IDLE with only cpuRead=1 the FSM SHALL go to RD; with neither request it SHALL stay in IDLE.
REQ-023 An access SHALL be misaligned when it is a word with addr[1:0]!=0 or a halfword with addr[0]=1.
REQ-024 A misaligned access SHALL go IDLE->DONE, set errMisalign, issue no memReq, suppress the store, and load cpuRData=0.
REQ-025 memReq, memWe, memAddr and memWData SHALL be held constant from request entry until the cycle memAck is sampled high.
REQ-026 memReq SHALL be low in the cycle after the ack.
REQ-027 On ack, RD SHALL go to DONE and register the extracted and extended lane into cpuRData.
REQ-028 On ack, RMW_RD SHALL go to WR with memWData = memRData with the addressed lane(s) replaced by cpuWData low bits.
REQ-029 On ack, WR SHALL go to DONE.
REQ-030 Lanes SHALL be little-endian: byte k = bits[8k+7:8k]; halfword at addr[1] = bits[16*addr[1]+15:16*addr[1]].
REQ-031 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-032 cpuStall SHALL be combinational: high in RD, RMW_RD and WR, and in IDLE when a request is present; low in DONE and in IDLE with no request.
REQ-033 Word-load latency SHALL be 2 cycles plus wait cycles: accept at cycle 0, ack at cycle 1 at the earliest, stall low at cycle 2.
REQ-034 Sub-word store latency SHALL be 3 cycles plus wait cycles.
REQ-035 A wait counter SHALL clear on entry to each request state and increment each cycle without ack.
REQ-036 When the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL drop memReq, set errTimeout, go to DONE, and set cpuRData=0 for loads.
REQ-037 A memAck in IDLE or DONE SHALL be ignored.
REQ-038 cpuRData SHALL hold its value until the next completed load.
REQ-039 Error flags SHALL clear only on rst.

Reset
REQ-040 rst high at a clock edge SHALL force: state IDLE, memReq=0, memWe=0, memAddr=0, memWData=0, cpuRData=0, errMisalign=0, errTimeout=0, wait counter=0.
REQ-041 Reset mid-transaction SHALL abandon the transaction with no retry; a late memAck is ignored per REQ-037.
REQ-042 cpuStall during rst SHALL follow REQ-032 with state IDLE.

Structure
REQ-043 Package mem_bridge_pkg SHALL hold the state enum and the MODE_WORD/MODE_HALF/MODE_BYTE constants.
REQ-044 One combinational sub-module, byte_lane, SHALL perform lane extraction with sign/zero extension and lane merge; it is shared by RD and RMW_RD.

Verification
REQ-045 Word load: addr 0x104, memRData 0xDEADBEEF, ack at 3rd req cycle -> cpuRData=0xDEADBEEF, stall high 4 cycles.
REQ-046 Signed byte load: addr 0x103, memRData 0x80112233, cpuSigned=1 -> cpuRData=0xFFFFFF80; with cpuSigned=0 -> 0x00000080.
REQ-047 Halfword store: addr 0x102, cpuWData 0x0000ABCD, RMW read 0x11223344 -> WR memWData=0xABCD3344, memAddr=0x100.
REQ-048 Misaligned word store at 0x105 -> no memReq, errMisalign=1, DONE after 1 cycle.
REQ-049 No ack, TIMEOUT_CYCLES=4 -> memReq drops after 4 cycles, errTimeout=1, cpuRData=0.
REQ-050 rst asserted in RMW_RD -> next cycle memReq=0, state IDLE; a subsequent ack causes no write.
